// File: rtl/seven_segment_decoder.sv
// Bus monitor for a four-digit multiplexed seven-segment display: rebuilds the
// shown hex value, digit-enable mask and decimal-point mask once per scan.
module seven_segment_decoder #(
  parameter int COUNT_BITS    = 17,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  anode,
  input  logic [7:0]  segment,
  output logic [15:0] dataOut,
  output logic [3:0]  digitEnabled,
  output logic [3:0]  digitPointOut,
  output logic        frameValid,
  output logic        frameError
);

  localparam int                TO_W   = COUNT_BITS + 1;
  localparam logic [7:0]        SETTLE = 8'(SETTLE_CYCLES);
  localparam logic [TO_W-1:0]   TO_ONE = {{(TO_W-1){1'b0}}, 1'b1};
  localparam logic [TO_W-1:0]   TO_MAX = {TO_W{1'b1}};

  typedef enum logic {WAIT_STABLE, HELD} state_t;

  // Returns {legal, nibble}; unknown patterns give nibble 0.
  function automatic logic [4:0] decode_hex(input logic [6:0] seg);
    case (seg)
      7'b1000000: return 5'h10;
      7'b1111001: return 5'h11;
      7'b0100100: return 5'h12;
      7'b0110000: return 5'h13;
      7'b0011001: return 5'h14;
      7'b0010010: return 5'h15;
      7'b0000010: return 5'h16;
      7'b1111000: return 5'h17;
      7'b0000000: return 5'h18;
      7'b0010000: return 5'h19;
      7'b0001000: return 5'h1A;
      7'b0000011: return 5'h1B;
      7'b1000110: return 5'h1C;
      7'b0100001: return 5'h1D;
      7'b0000110: return 5'h1E;
      7'b0001110: return 5'h1F;
      default:    return 5'h00;
    endcase
  endfunction

  // Returns {exactly_one_low, index} for an active-low anode vector.
  function automatic logic [2:0] anode_index(input logic [3:0] an);
    case (an)
      4'b1110: return 3'b100;
      4'b1101: return 3'b101;
      4'b1011: return 3'b110;
      4'b0111: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    if (c >= SETTLE) return SETTLE;
    return c + 8'd1;
  endfunction

  logic [3:0]      anode_q;
  logic [7:0]      segment_q;
  logic [11:0]     pair_prev_q;
  logic [7:0]      stab_q, stab_d;
  state_t          state_q, state_d;
  logic [15:0]     acc_data_q, acc_data_d;
  logic [3:0]      acc_en_q, acc_en_d;
  logic [3:0]      acc_dp_q, acc_dp_d;
  logic            acc_err_q, acc_err_d;
  logic [1:0]      prev_idx_q, prev_idx_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [15:0]     data_out_q, data_out_d;
  logic [3:0]      en_out_q, en_out_d;
  logic [3:0]      dp_out_q, dp_out_d;
  logic            err_out_q, err_out_d;
  logic            valid_q, valid_d;

  logic [11:0]     pair_now;
  logic            changed, capture;
  logic [2:0]      an_info;
  logic [4:0]      dec;
  logic [1:0]      idx;

  // Stability tracking and capture FSM over the registered bus copy
  always_comb begin
    pair_now = {anode_q, segment_q};
    changed  = (pair_now != pair_prev_q);
    stab_d   = changed ? 8'd1 : sat_inc(stab_q);
    capture  = (stab_d == SETTLE) && (anode_q != 4'hF) &&
               ((state_q == WAIT_STABLE) || changed);
    state_d  = state_q;
    if (capture)      state_d = HELD;
    else if (changed) state_d = WAIT_STABLE;
  end

  // Frame accumulator, wrap detection, idle timeout and publish
  always_comb begin
    an_info    = anode_index(anode_q);
    idx        = an_info[1:0];
    dec        = decode_hex(segment_q[6:0]);
    acc_data_d = acc_data_q;
    acc_en_d   = acc_en_q;
    acc_dp_d   = acc_dp_q;
    acc_err_d  = acc_err_q;
    prev_idx_d = prev_idx_q;
    to_d       = to_q + TO_ONE;
    data_out_d = data_out_q;
    en_out_d   = en_out_q;
    dp_out_d   = dp_out_q;
    err_out_d  = err_out_q;
    valid_d    = 1'b0;
    if (capture) begin
      to_d = '0;
      if (an_info[2]) begin
        if ((acc_en_q != 4'b0) && (idx <= prev_idx_q)) begin
          valid_d    = 1'b1;
          acc_data_d = '0;
          acc_en_d   = '0;
          acc_dp_d   = '0;
          acc_err_d  = 1'b0;
        end
        acc_data_d[{idx, 2'b00} +: 4] = dec[3:0];
        acc_en_d[idx]  = 1'b1;
        acc_dp_d[idx]  = ~segment_q[7];
        acc_err_d      = acc_err_d | ~dec[4];
        prev_idx_d     = idx;
      end else begin
        acc_err_d = 1'b1;
      end
    end else if (to_q == TO_MAX) begin
      valid_d    = 1'b1;
      to_d       = '0;
      acc_data_d = '0;
      acc_en_d   = '0;
      acc_dp_d   = '0;
      acc_err_d  = 1'b0;
      prev_idx_d = '0;
    end
    // Published values always come from the accumulator as it stood before this edge.
    if (valid_d) begin
      data_out_d = acc_data_q;
      en_out_d   = acc_en_q;
      dp_out_d   = acc_dp_q;
      err_out_d  = acc_err_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anode_q     <= 4'hF;
      segment_q   <= 8'hFF;
      pair_prev_q <= 12'hFFF;
      stab_q      <= '0;
      state_q     <= WAIT_STABLE;
      acc_data_q  <= '0;
      acc_en_q    <= '0;
      acc_dp_q    <= '0;
      acc_err_q   <= 1'b0;
      prev_idx_q  <= '0;
      to_q        <= '0;
      data_out_q  <= '0;
      en_out_q    <= '0;
      dp_out_q    <= '0;
      err_out_q   <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      anode_q     <= anode;
      segment_q   <= segment;
      pair_prev_q <= pair_now;
      stab_q      <= stab_d;
      state_q     <= state_d;
      acc_data_q  <= acc_data_d;
      acc_en_q    <= acc_en_d;
      acc_dp_q    <= acc_dp_d;
      acc_err_q   <= acc_err_d;
      prev_idx_q  <= prev_idx_d;
      to_q        <= to_d;
      data_out_q  <= data_out_d;
      en_out_q    <= en_out_d;
      dp_out_q    <= dp_out_d;
      err_out_q   <= err_out_d;
      valid_q     <= valid_d;
    end
  end

  assign dataOut       = data_out_q;
  assign digitEnabled  = en_out_q;
  assign digitPointOut = dp_out_q;
  assign frameValid    = valid_q;
  assign frameError    = err_out_q;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Directed bench for seven_segment_decoder: scans of 0x1234 with glitch,
// blank-digit, multi-anode, idle-timeout and mid-scan reset cases.
module tb_seven_segment_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  anode;
  logic [7:0]  segment;
  logic [15:0] dataOut;
  logic [3:0]  digitEnabled;
  logic [3:0]  digitPointOut;
  logic        frameValid;
  logic        frameError;

  int n_checks = 0;
  int n_pass   = 0;
  int nframes  = 0;
  int cyc      = 0;
  int last_cyc = 0;
  int prev_cyc = 0;
  int nf0;
  logic [15:0] f_data = '0;
  logic [3:0]  f_en = '0, f_dp = '0;
  logic        f_err = 1'b0;

  // Digit i shows nibble i of 0x1234; decimal point lit on digit 2.
  localparam logic [7:0] SEG0 = 8'b10011001;
  localparam logic [7:0] SEG1 = 8'b10110000;
  localparam logic [7:0] SEG2 = 8'b00100100;
  localparam logic [7:0] SEG3 = 8'b11111001;

  seven_segment_decoder #(.COUNT_BITS(6), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .anode(anode), .segment(segment),
    .dataOut(dataOut), .digitEnabled(digitEnabled), .digitPointOut(digitPointOut),
    .frameValid(frameValid), .frameError(frameError)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (frameValid === 1'b1) begin
      nframes  = nframes + 1;
      prev_cyc = last_cyc;
      last_cyc = cyc;
      f_data   = dataOut;
      f_en     = digitEnabled;
      f_dp     = digitPointOut;
      f_err    = frameError;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input logic [3:0] a, input logic [7:0] s, input int n);
    anode   = a;
    segment = s;
    repeat (n) @(negedge clk);
  endtask

  // mode 0 clean, 1 glitch in digit 1, 2 blank digit 3, 3 two anodes in slot 1
  task automatic run_scan(input int mode);
    drive(4'b1110, SEG0, 16);
    if (mode == 1) begin
      drive(4'b1101, SEG1, 1);
      drive(4'b1101, 8'h80, 2);
      drive(4'b1101, SEG1, 13);
    end else if (mode == 3) begin
      drive(4'b1100, SEG1, 16);
    end else begin
      drive(4'b1101, SEG1, 16);
    end
    drive(4'b1011, SEG2, 16);
    drive(4'b0111, (mode == 2) ? 8'hFF : SEG3, 16);
  endtask

  task automatic check_frame(input string tag, input int d, input int en, input int dp, input int err);
    #1;
    chk({tag, ".data"}, int'(f_data), d);
    chk({tag, ".en"},   int'(f_en),   en);
    chk({tag, ".dp"},   int'(f_dp),   dp);
    chk({tag, ".err"},  int'(f_err),  err);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, ".dataOut"},    int'(dataOut),       0);
    chk({tag, ".enabled"},    int'(digitEnabled),  0);
    chk({tag, ".point"},      int'(digitPointOut), 0);
    chk({tag, ".frameValid"}, int'(frameValid),    0);
    chk({tag, ".frameError"}, int'(frameError),    0);
  endtask

  initial begin
    reset   = 1'b1;
    anode   = 4'hF;
    segment = 8'hFF;
    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    repeat (3) run_scan(0);
    #1;
    chk("frames_after_3_scans", nframes, 2);
    chk("frame_interval", last_cyc - prev_cyc, 64);
    check_frame("clean", 'h1234, 'hF, 'h4, 0);

    run_scan(1);
    run_scan(0);
    #1;
    chk("frames_after_glitch", nframes, 4);
    check_frame("glitch", 'h1234, 'hF, 'h4, 0);

    run_scan(2);
    run_scan(0);
    check_frame("blank_d3", 'h0234, 'hF, 'h4, 1);
    run_scan(0);
    check_frame("after_blank", 'h1234, 'hF, 'h4, 0);

    run_scan(3);
    run_scan(0);
    check_frame("multi_anode", 'h1204, 'hD, 'h4, 1);

    nf0 = nframes;
    drive(4'hF, 8'hFF, 200);
    #1;
    chk("timeout_first_count", nframes - nf0, 1);
    check_frame("timeout_first", 'h1234, 'hF, 'h4, 0);
    drive(4'hF, 8'hFF, 100);
    #1;
    chk("timeout_empty_count", nframes - nf0, 2);
    check_frame("timeout_empty", 0, 0, 0, 0);

    run_scan(0);
    run_scan(0);
    #1;
    chk("pre_reset_data", int'(dataOut), 'h1234);
    drive(4'b1110, SEG0, 16);
    drive(4'b1101, SEG1, 16);
    drive(4'b1011, SEG2, 8);
    reset = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    nf0 = nframes;
    drive(4'b1011, SEG2, 7);
    drive(4'b0111, SEG3, 16);
    run_scan(0);
    #1;
    chk("post_reset_count", nframes - nf0, 1);
    check_frame("post_reset", 'h1200, 'hC, 'h4, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
